if_fetch_unit: RTL and testbench

//   Instruction-fetch stage: owns the PC register, issues one instruction-memory

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 tb/tb_if_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request and
// IF/ID presentation. Optional macro IF_ALIGN_CHECK_EN enables fetch-alignment exceptions.
module if_fetch_unit #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0000_3000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] PC_if,
   output logic [31:0]       Inst_if,
   output logic              if_valid,
   output logic              if_exc
);

   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_pc_if, w_pc_if_nxt;
   logic [31:0]       r_inst, w_inst_nxt;
   logic              r_drop, w_drop_nxt;
   logic              r_exc, w_exc_nxt;
   logic              w_misalign;

`ifdef IF_ALIGN_CHECK_EN
   assign w_misalign = |r_pc[1:0];
`else
   assign w_misalign = 1'b0;
`endif

   assign imem_addr = r_pc;
   assign PC_if     = r_pc_if;
   assign Inst_if   = r_inst;
   assign if_exc    = r_exc;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pc_if_nxt = r_pc_if;
      w_inst_nxt  = r_inst;
      w_drop_nxt  = r_drop;
      w_exc_nxt   = r_exc;
      imem_req    = 1'b0;
      if_valid    = 1'b0;
      case (r_state)
         S_REQ: begin
            imem_req = !redirect_valid && !w_misalign;
            if (redirect_valid) begin
               w_pc_nxt = redirect_pc;
            end else if (w_misalign) begin
               // Misaligned fetch never reaches imem; present a NOP flagged as an exception.
               w_state_nxt = S_HOLD;
               w_inst_nxt  = 32'h0;
               w_pc_if_nxt = r_pc;
               w_exc_nxt   = 1'b1;
            end else if (imem_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               w_pc_nxt = redirect_pc;
               if (imem_rvalid) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else begin
                  w_drop_nxt  = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else begin
                  w_inst_nxt  = imem_rdata;
                  w_pc_if_nxt = r_pc;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if_valid = !redirect_valid;
            if (redirect_valid) begin
               w_pc_nxt    = redirect_pc;
               w_exc_nxt   = 1'b0;
               w_state_nxt = S_REQ;
            end else if (!stall) begin
               w_pc_nxt    = r_pc + ADDR_W'(4);
               w_exc_nxt   = 1'b0;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase
      if (rst) begin
         imem_req = 1'b0;
         if_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_pc_if <= '0;
         r_inst  <= 32'h0;
         r_drop  <= 1'b0;
         r_exc   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_pc_if <= w_pc_if_nxt;
         r_inst  <= w_inst_nxt;
         r_drop  <= w_drop_nxt;
         r_exc   <= w_exc_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; imem responder returns {16'hC0DE, addr[15:0]}
// after a programmable latency.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid, imem_ready;
   logic [31:0] redirect_pc;
   logic        imem_req, if_valid, if_exc;
   logic [31:0] imem_addr, PC_if, Inst_if;
   logic        mem_rvalid, inj_rvalid, imem_rvalid;
   logic [31:0] imem_rdata;

   int          lat;
   logic        pend;
   int          cnt;
   logic [31:0] paddr;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rvalid = mem_rvalid | inj_rvalid;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PC_if(PC_if), .Inst_if(Inst_if), .if_valid(if_valid), .if_exc(if_exc)
   );

   // Instruction memory: response lat cycles after the accepting edge.
   always @(posedge clk) begin
      if (rst) begin
         pend       <= 1'b0;
         mem_rvalid <= 1'b0;
         imem_rdata <= 32'h0;
         cnt        <= 0;
         paddr      <= 32'h0;
      end else begin
         mem_rvalid <= 1'b0;
         if (imem_req && imem_ready) begin
            if (lat == 1) begin
               mem_rvalid <= 1'b1;
               imem_rdata <= {16'hC0DE, imem_addr[15:0]};
            end else begin
               pend  <= 1'b1;
               cnt   <= lat - 1;
               paddr <= imem_addr;
            end
         end else if (pend) begin
            if (cnt == 1) begin
               mem_rvalid <= 1'b1;
               imem_rdata <= {16'hC0DE, paddr[15:0]};
               pend       <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_ready = 1'b1; inj_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_ready = 1'b1; inj_rvalid = 1'b0; lat = 1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", if_valid); end
      n_checks++; if (PC_if !== 32'h0) begin n_fail++; $display("FAIL rst_pcif got %h want 0", PC_if); end
      n_checks++; if (Inst_if !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", Inst_if); end
      n_checks++; if (if_exc !== 1'b0) begin n_fail++; $display("FAIL rst_exc got %b want 0", if_exc); end
      rst = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got %b want 1", imem_req); end
      n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rel_addr got %h want 3000", imem_addr); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_in [3];
      exp_pc = '{32'h3000, 32'h3004, 32'h3008};
      exp_in = '{32'hC0DE3000, 32'hC0DE3004, 32'hC0DE3008};
      lat = 1;
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (if_valid !== (i % 3 == 2)) begin n_fail++; $display("FAIL zw_valid cyc %0d got %b want %b", i, if_valid, (i % 3 == 2)); end
         if (i % 3 == 2) begin
            n_checks++; if (PC_if !== exp_pc[(i-2)/3]) begin n_fail++; $display("FAIL zw_pc cyc %0d got %h want %h", i, PC_if, exp_pc[(i-2)/3]); end
            n_checks++; if (Inst_if !== exp_in[(i-2)/3]) begin n_fail++; $display("FAIL zw_inst cyc %0d got %h want %h", i, Inst_if, exp_in[(i-2)/3]); end
         end
      end
   endtask

   task automatic test_long_wait();
      lat = 3;
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); #1;
         n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL lw_req cyc %0d got %b want 0", i, imem_req); end
         n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL lw_valid cyc %0d got %b want 0", i, if_valid); end
      end
      @(negedge clk); #1;
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL lw_hold got %b want 1", if_valid); end
      n_checks++; if (PC_if !== 32'h3000) begin n_fail++; $display("FAIL lw_pc got %h want 3000", PC_if); end
      n_checks++; if (Inst_if !== 32'hC0DE3000) begin n_fail++; $display("FAIL lw_inst got %h want C0DE3000", Inst_if); end
      @(negedge clk); #1;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL lw_single got %b want 0", if_valid); end
      n_checks++; if (imem_addr !== 32'h3004) begin n_fail++; $display("FAIL lw_next got %h want 3004", imem_addr); end
   endtask

   task automatic test_stall();
      lat = 1;
      do_reset();
      repeat (2) @(negedge clk);
      stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) stall = 1'b0;
         n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid cyc %0d got %b want 1", i, if_valid); end
         n_checks++; if (PC_if !== 32'h3000) begin n_fail++; $display("FAIL st_pc cyc %0d got %h want 3000", i, PC_if); end
         n_checks++; if (Inst_if !== 32'hC0DE3000) begin n_fail++; $display("FAIL st_inst cyc %0d got %h want C0DE3000", i, Inst_if); end
         @(negedge clk); #1;
      end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL st_next got req=%b addr=%h want req=1 addr=3004", imem_req, imem_addr); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL st_after got %b want 0", if_valid); end
   endtask

   task automatic test_redirect_wait();
      lat = 3;
      do_reset();
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h4000;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int i = 2; i <= 3; i++) begin
         #1;
         n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_wait cyc %0d got valid=%b req=%b want 0 0", i, if_valid, imem_req); end
         @(negedge clk);
      end
      #1;
      lat = 1;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drop got %b want 0", if_valid); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000) begin n_fail++; $display("FAIL rw_addr got req=%b addr=%h want req=1 addr=4000", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (if_valid !== 1'b1 || PC_if !== 32'h4000) begin n_fail++; $display("FAIL rw_new got valid=%b pc=%h want 1 4000", if_valid, PC_if); end
      n_checks++; if (Inst_if !== 32'hC0DE4000) begin n_fail++; $display("FAIL rw_inst got %h want C0DE4000", Inst_if); end
      // Redirect coinciding with the response, then redirect while still requesting.
      do_reset();
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h4000;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h4000 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rwr got valid=%b req=%b addr=%h want 0 1 4000", if_valid, imem_req, imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h5000;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rq_noreq got %b want 0", imem_req); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin n_fail++; $display("FAIL rq_addr got req=%b addr=%h want 1 5000", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_stall_hold();
      lat = 1;
      do_reset();
      repeat (2) @(negedge clk);
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4000;
      #1;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b want 0", if_valid); end
      @(negedge clk);
      stall = 1'b0; redirect_valid = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000) begin n_fail++; $display("FAIL rs_addr got req=%b addr=%h want 1 4000", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (if_valid !== 1'b1 || PC_if !== 32'h4000) begin n_fail++; $display("FAIL rs_new got valid=%b pc=%h want 1 4000", if_valid, PC_if); end
`ifdef IF_ALIGN_CHECK_EN
      do_reset();
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h4002;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL al_noreq got %b want 0", imem_req); end
      @(negedge clk); #1;
      n_checks++; if (if_exc !== 1'b1 || if_valid !== 1'b1) begin n_fail++; $display("FAIL al_exc got exc=%b valid=%b want 1 1", if_exc, if_valid); end
      n_checks++; if (Inst_if !== 32'h0 || PC_if !== 32'h4002) begin n_fail++; $display("FAIL al_nop got inst=%h pc=%h want 0 4002", Inst_if, PC_if); end
      @(negedge clk); #1;
      n_checks++; if (if_exc !== 1'b0) begin n_fail++; $display("FAIL al_clr got %b want 0", if_exc); end
`endif
   endtask

   task automatic test_wrap();
      lat = 1;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (if_valid !== 1'b1 || PC_if !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_pc got valid=%b pc=%h want 1 FFFFFFFC", if_valid, PC_if); end
      n_checks++; if (Inst_if !== 32'hC0DEFFFC) begin n_fail++; $display("FAIL wr_inst got %h want C0DEFFFC", Inst_if); end
      @(negedge clk); #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_next got req=%b addr=%h want 1 0", imem_req, imem_addr); end
   endtask

   task automatic test_spurious_rvalid();
      lat = 1;
      do_reset();
      imem_ready = 1'b0; inj_rvalid = 1'b1;
      @(negedge clk);
      inj_rvalid = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || if_valid !== 1'b0) begin n_fail++; $display("FAIL sp_req got req=%b addr=%h valid=%b want 1 3000 0", imem_req, imem_addr, if_valid); end
      imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      stall = 1'b1; inj_rvalid = 1'b1;
      @(negedge clk);
      inj_rvalid = 1'b0;
      #1;
      n_checks++; if (if_valid !== 1'b1 || PC_if !== 32'h3000 || Inst_if !== 32'hC0DE3000) begin n_fail++; $display("FAIL sp_hold got valid=%b pc=%h inst=%h want 1 3000 C0DE3000", if_valid, PC_if, Inst_if); end
      stall = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_ready = 1'b1; inj_rvalid = 1'b0; lat = 1;
      test_reset();
      test_zero_wait();
      test_long_wait();
      test_stall();
      test_redirect_wait();
      test_redirect_stall_hold();
      test_wrap();
      test_spurious_rvalid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
